fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Parametrised instruction prefetcher, the next generation of the core's fetch stage. Issues AXI4 INCR read bursts ahead of the decoder and queues {pc, instr, pred, err} in an internal FIFO. Follows JAL and (optionally) backward conditional branches. Handles flushes that land mid-burst by draining the stale burst, and reports bus errors per instruction.

## Interface

- FIFO_DEPTH, 16: entries in the instruction queue; power of 2, ≥4.
- BURST_LEN, 4: maximum beats per AR burst; 1..FIFO_DEPTH/2.
- RESET_PC, 32'h0000_0000: fetch address after reset.
- BTFN_EN, 1: 1 = predict backward conditional branches as taken.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- o_instr  out  32  instruction at the queue head.
- o_pc  out  32  PC of the head instruction.
- o_pred  out  1  head instruction caused a predicted redirect.
- o_err  out  1  head beat returned RRESP≠OKAY; o_instr is invalid.
- o_valid  out  1  queue not empty.
- o_next  in  1  pop the head; ignored when o_valid=0.
- c_flush  in  1  redirect request; single-cycle pulse.
- c_pc  in  32  redirect target; bits [1:0] are forced to 0.
- m_axi_araddr/arlen/arsize/arburst/arvalid  out  32/8/3/2/1  AXI AR channel.
- m_axi_arready  in  1  AXI AR ready.
- m_axi_rdata/rresp/rlast/rvalid  in  32/2/1/1  AXI R channel.
- m_axi_rready  out  1  AXI R ready.

## Operation

- States: IDLE, ADDR, DATA, DRAIN. Registers: next_pc, pend_pc, pend_flush, halt.
- Credit rule: credits = FIFO_DEPTH − count − beats_inflight.
- IDLE → ADDR when halt=0 and credits ≥ len.
  - len = min(BURST_LEN, words left before the next 4 KB boundary of next_pc).
  - Drive araddr=next_pc, arlen=len−1, arsize=3'b010, arburst=2'b01.
- ADDR → DATA on arready. rready=1 for the whole DATA and DRAIN period.
- On each accepted beat in DATA, push {pc, rdata, pred, err=(rresp≠0)}. Update next_pc by decoding rdata[6:0]:
  - 1101111 (JAL): next_pc = pc + J-imm; pred=1; remaining beats of the burst are dropped.
  - 1100011 (branch) with imm<0 and BTFN_EN=1: next_pc = pc + B-imm; pred=1; remaining beats dropped.
  - 1100111 (JALR): pred=0; halt=1 until c_flush; remaining beats dropped.
  - rresp≠0: err=1; halt=1 until c_flush; remaining beats dropped.
  - Otherwise: next_pc += 4.
- DATA → IDLE on rlast.
- Dropped beats are accepted (rready=1) but not pushed.
- c_flush in IDLE: queue cleared; next_pc=c_pc; halt=0.
- c_flush in ADDR or DATA:
  - Queue cleared; pend_pc=c_pc; pend_flush=1; halt=0.
  - ADDR completes its handshake, then DRAIN. DATA → DRAIN.
  - No beats of the old burst are pushed, including the flush cycle's own beat.
- DRAIN: discard beats. On rlast → IDLE with next_pc=pend_pc; pend_flush cleared.
- Repeated flushes: the latest c_pc wins.
- Flush and o_next in the same cycle: flush wins; pop ignored.
- Push and pop in the same cycle: both performed; count unchanged.
- Arithmetic: PC adds are 32-bit and wrap modulo 2^32. Immediates are sign-extended.

## Timing

- Reset values:
  - arvalid=0, rready=0, o_valid=0, o_pred=0, o_err=0.
  - araddr=0, arlen=0, arsize=3'b010, arburst=2'b01.
  - next_pc=RESET_PC; halt=0; state IDLE; queue empty.
- Reset mid-burst abandons the burst. The AXI slave must also be reset.
- arvalid rises the cycle after the IDLE issue decision and holds, with address stable, until arready.
- Beat accepted in cycle T → o_valid / head fields valid at T+1.
- o_* are driven from registered queue storage.
- Flush at cycle T with idle bus, arready=1 and first rvalid at T+2:
  - arvalid=1 at T+1; beat accepted at T+2; o_valid=1 at T+3.
- o_valid=0 from cycle T+1 after any flush at T.
- A full queue never back-pressures R, because credits are reserved at issue.

## Test plan

- Reset with RESET_PC=0x100, slave returns 4 NOPs → AR addr 0x100, len 3. Queue gets PCs 0x100, 0x104, 0x108, 0x10C, pred=0.
- Beat 2 at 0x204 is JAL +0x40 → beats 3–4 dropped. Next AR addr 0x244; entry 0x204 has pred=1.
- Branch at 0x300 with imm −8, BTFN_EN=1 → next AR at 0x2F8. Same test with BTFN_EN=0 → next AR at 0x304.
- c_flush(0x800) during beat 2 of a 4-beat burst → o_valid=0 next cycle. Beats 2–4 discarded. Next AR at 0x800 only after rlast.
- next_pc=0xFF8, BURST_LEN=4 → arlen=1 (4 KB boundary). Next burst at 0x1000.
- rresp=SLVERR on beat 1 → entry err=1; no further AR until c_flush. Hold o_next=0 with FIFO_DEPTH=4 → no AR issued while credits < len.

Source files
------------

// File: rtl/fetch_prefetch_if.sv
// AXI4 read channels (AR + R) between the instruction prefetcher (master) and memory (slave).
interface fetch_prefetch_if;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: AXI4 INCR bursts into a {pc, instr, pred, err} queue; beat visible at head 1 cycle later.
// R is never back-pressured: queue slots are reserved at AR issue, so a burst only starts when it is guaranteed to fit.
module fetch_prefetch #(
   parameter int          FIFO_DEPTH = 16,
   parameter int          BURST_LEN  = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter bit          BTFN_EN    = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [31:0]      o_instr,
   output logic [31:0]      o_pc,
   output logic             o_pred,
   output logic             o_err,
   output logic             o_valid,
   input  logic             o_next,
   input  logic             c_flush,
   input  logic [31:0]      c_pc,
   fetch_prefetch_if.master m_axi
);
   localparam int          AW = $clog2(FIFO_DEPTH);
   localparam int          CW = AW + 1;
   localparam logic [10:0] BL = 11'(BURST_LEN);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
      logic        err;
   } ent_t;

   state_t        state_q, state_d;
   logic [31:0]   next_pc_q, next_pc_d;
   logic [31:0]   pend_pc_q, pend_pc_d;
   logic [31:0]   beat_pc_q, beat_pc_d;
   logic [31:0]   araddr_q, araddr_d;
   logic [7:0]    arlen_q, arlen_d;
   logic          arvalid_q, arvalid_d;
   logic          rready_q, rready_d;
   logic          pend_flush_q, pend_flush_d;
   logic          halt_q, halt_d;
   logic          drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   ent_t          mem_q [FIFO_DEPTH];

   logic          push, pop, beat;
   ent_t          push_ent, head;
   logic [31:0]   flush_pc, issue_pc, j_imm, b_imm;
   logic [10:0]   words_left, len;
   logic [CW-1:0] credits;

   assign flush_pc = c_pc & 32'hFFFF_FFFC;
   assign beat     = m_axi.rvalid & rready_q;
   assign j_imm    = {{12{m_axi.rdata[31]}}, m_axi.rdata[19:12], m_axi.rdata[20], m_axi.rdata[30:21], 1'b0};
   assign b_imm    = {{20{m_axi.rdata[31]}}, m_axi.rdata[7], m_axi.rdata[30:25], m_axi.rdata[11:8], 1'b0};

   // A flush in IDLE issues straight to the new target in the same cycle, against an emptied queue.
   assign issue_pc   = c_flush ? flush_pc : next_pc_q;
   assign words_left = 11'd1024 - {1'b0, issue_pc[11:2]};
   assign len        = (words_left < BL) ? words_left : BL;
   assign credits    = CW'(FIFO_DEPTH) - (c_flush ? '0 : count_q) - inflight_q;

   always_comb begin
      state_d      = state_q;
      next_pc_d    = next_pc_q;
      pend_pc_d    = pend_pc_q;
      beat_pc_d    = beat_pc_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      pend_flush_d = pend_flush_q;
      halt_d       = halt_q;
      drop_d       = drop_q;
      inflight_d   = inflight_q;
      push         = 1'b0;
      pop          = o_next && (count_q != '0) && !c_flush;
      push_ent     = '{pc: beat_pc_q, instr: m_axi.rdata, pred: 1'b0, err: (m_axi.rresp != 2'b00)};

      case (state_q)
         S_IDLE: begin
            if (c_flush) begin
               next_pc_d = flush_pc;
               halt_d    = 1'b0;
            end
            if ((!halt_q || c_flush) && (11'(credits) >= len)) begin
               state_d    = S_ADDR;
               arvalid_d  = 1'b1;
               araddr_d   = issue_pc;
               arlen_d    = 8'(len - 11'd1);
               inflight_d = CW'(len);
               beat_pc_d  = issue_pc;
               drop_d     = 1'b0;
            end
         end
         S_ADDR: begin
            if (c_flush) begin
               pend_pc_d    = flush_pc;
               pend_flush_d = 1'b1;
               halt_d       = 1'b0;
            end
            if (m_axi.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = (c_flush || pend_flush_q) ? S_DRAIN : S_DATA;
            end
         end
         S_DATA: begin
            if (c_flush) begin
               pend_pc_d    = flush_pc;
               pend_flush_d = 1'b1;
               halt_d       = 1'b0;
               state_d      = S_DRAIN;
            end
            if (beat) begin
               inflight_d = inflight_q - CW'(1);
               beat_pc_d  = beat_pc_q + 32'd4;
               if (!c_flush && !drop_q) begin
                  push = 1'b1;
                  if (m_axi.rresp != 2'b00) begin
                     halt_d = 1'b1;
                     drop_d = 1'b1;
                  end else if (m_axi.rdata[6:0] == 7'b1101111) begin
                     next_pc_d     = beat_pc_q + j_imm;
                     push_ent.pred = 1'b1;
                     drop_d        = 1'b1;
                  end else if (BTFN_EN && (m_axi.rdata[6:0] == 7'b1100011) && m_axi.rdata[31]) begin
                     next_pc_d     = beat_pc_q + b_imm;
                     push_ent.pred = 1'b1;
                     drop_d        = 1'b1;
                  end else if (m_axi.rdata[6:0] == 7'b1100111) begin
                     halt_d = 1'b1;
                     drop_d = 1'b1;
                  end else begin
                     next_pc_d = beat_pc_q + 32'd4;
                  end
               end
               // A flush landing on the final beat has nothing left to drain.
               if (m_axi.rlast) begin
                  state_d      = S_IDLE;
                  rready_d     = 1'b0;
                  drop_d       = 1'b0;
                  inflight_d   = '0;
                  pend_flush_d = 1'b0;
                  if (c_flush) next_pc_d = flush_pc;
               end
            end
         end
         S_DRAIN: begin
            if (c_flush) begin
               pend_pc_d = flush_pc;
               halt_d    = 1'b0;
            end
            if (beat) begin
               inflight_d = inflight_q - CW'(1);
               if (m_axi.rlast) begin
                  state_d      = S_IDLE;
                  rready_d     = 1'b0;
                  inflight_d   = '0;
                  pend_flush_d = 1'b0;
                  next_pc_d    = c_flush ? flush_pc : pend_pc_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (c_flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d  = count_q + CW'(push) - CW'(pop);
         rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
         wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         next_pc_q    <= RESET_PC;
         pend_pc_q    <= '0;
         beat_pc_q    <= '0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         pend_flush_q <= 1'b0;
         halt_q       <= 1'b0;
         drop_q       <= 1'b0;
         count_q      <= '0;
         inflight_q   <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         next_pc_q    <= next_pc_d;
         pend_pc_q    <= pend_pc_d;
         beat_pc_q    <= beat_pc_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         pend_flush_q <= pend_flush_d;
         halt_q       <= halt_d;
         drop_q       <= drop_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_ent;
   end

   // Queue storage is not reset, so the flag outputs are qualified by occupancy.
   assign head    = mem_q[rd_ptr_q];
   assign o_valid = (count_q != '0);
   assign o_pc    = head.pc;
   assign o_instr = head.instr;
   assign o_pred  = o_valid & head.pred;
   assign o_err   = o_valid & head.err;

   assign m_axi.araddr  = araddr_q;
   assign m_axi.arlen   = arlen_q;
   assign m_axi.arsize  = 3'b010;
   assign m_axi.arburst = 2'b01;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: two instances (BTFN on / FIFO 16, BTFN off / FIFO 4) against a simple AXI read slave.
`timescale 1ns/1ps
module tb_fetch_prefetch;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] JAL_P40 = 32'h0400_006F;
   localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        c_flush [2];
   logic [31:0] c_pc    [2];
   logic        o_next  [2];
   logic [31:0] o_instr [2];
   logic [31:0] o_pc    [2];
   logic        o_pred  [2];
   logic        o_err   [2];
   logic        o_valid [2];

   fetch_prefetch_if bus [2] ();

   logic        m_arvalid [2];
   logic        m_rready  [2];
   logic [31:0] m_araddr  [2];
   logic [7:0]  m_arlen   [2];
   logic [2:0]  m_arsize  [2];
   logic [1:0]  m_arburst [2];
   logic        s_busy    [2];
   logic [31:0] s_cur     [2];
   logic [8:0]  s_rem     [2];

   int          ar_cnt [2];
   int          ar_rd  [2];
   logic [31:0] ar_log_addr [2][64];
   logic [7:0]  ar_log_len  [2][64];
   int          checks   = 0;
   int          failures = 0;

   function automatic logic [31:0] imem(input logic [31:0] a);
      case (a)
         32'h0000_0204: imem = JAL_P40;
         32'h0000_0300: imem = BEQ_M8;
         default:       imem = NOP;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      fetch_prefetch #(
         .FIFO_DEPTH (g == 0 ? 16 : 4),
         .BURST_LEN  (g == 0 ? 4 : 2),
         .RESET_PC   (g == 0 ? 32'h0000_0100 : 32'h0000_02FC),
         .BTFN_EN    (g == 0)
      ) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .o_instr (o_instr[g]),
         .o_pc    (o_pc[g]),
         .o_pred  (o_pred[g]),
         .o_err   (o_err[g]),
         .o_valid (o_valid[g]),
         .o_next  (o_next[g]),
         .c_flush (c_flush[g]),
         .c_pc    (c_pc[g]),
         .m_axi   (bus[g])
      );
      assign m_arvalid[g]   = bus[g].arvalid;
      assign m_rready[g]    = bus[g].rready;
      assign m_araddr[g]    = bus[g].araddr;
      assign m_arlen[g]     = bus[g].arlen;
      assign m_arsize[g]    = bus[g].arsize;
      assign m_arburst[g]   = bus[g].arburst;
      assign bus[g].arready = ~s_busy[g];
      assign bus[g].rvalid  = s_busy[g];
      assign bus[g].rdata   = imem(s_cur[g]);
      assign bus[g].rresp   = (s_cur[g] == 32'h0000_2000) ? 2'b10 : 2'b00;
      assign bus[g].rlast   = (s_rem[g] == 9'd1);
   end

   // One burst at a time, first beat the cycle after the AR handshake, beats back to back.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            s_busy[k] <= 1'b0;
            s_cur[k]  <= '0;
            s_rem[k]  <= '0;
            ar_cnt[k] <= 0;
         end else if (!s_busy[k]) begin
            if (m_arvalid[k]) begin
               s_busy[k] <= 1'b1;
               s_cur[k]  <= m_araddr[k];
               s_rem[k]  <= 9'(m_arlen[k]) + 9'd1;
               ar_log_addr[k][ar_cnt[k] % 64] <= m_araddr[k];
               ar_log_len[k][ar_cnt[k] % 64]  <= m_arlen[k];
               ar_cnt[k] <= ar_cnt[k] + 1;
            end
         end else if (m_rready[k]) begin
            s_cur[k] <= s_cur[k] + 32'd4;
            s_rem[k] <= s_rem[k] - 9'd1;
            if (s_rem[k] == 9'd1) s_busy[k] <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_ar(input int inst, input string tag, input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      while (ar_cnt[inst] <= ar_rd[inst] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (ar_cnt[inst] <= ar_rd[inst]) begin
         check({tag, "_timeout"}, 32'(ar_cnt[inst]), 32'(ar_rd[inst] + 1));
      end else begin
         check({tag, "_addr"}, ar_log_addr[inst][ar_rd[inst] % 64], addr);
         check({tag, "_len"}, 32'(ar_log_len[inst][ar_rd[inst] % 64]), 32'(len));
         ar_rd[inst]++;
      end
   endtask

   task automatic pop_check(input int inst, input string tag, input logic [31:0] pc, input logic pred,
                            input logic err, input bit chk_instr, input logic [31:0] instr);
      int n = 0;
      while (!o_valid[inst] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!o_valid[inst]) begin
         check({tag, "_valid"}, 32'(o_valid[inst]), 32'd1);
      end else begin
         check({tag, "_pc"}, o_pc[inst], pc);
         check({tag, "_pred"}, 32'(o_pred[inst]), 32'(pred));
         check({tag, "_err"}, 32'(o_err[inst]), 32'(err));
         if (chk_instr) check({tag, "_instr"}, o_instr[inst], instr);
         o_next[inst] = 1'b1;
         @(negedge clk);
         o_next[inst] = 1'b0;
      end
   endtask

   task automatic do_flush(input int inst, input logic [31:0] pc);
      c_flush[inst] = 1'b1;
      c_pc[inst]    = pc;
      @(negedge clk);
      c_flush[inst] = 1'b0;
   endtask

   task automatic settle(input int inst);
      repeat (100) @(negedge clk);
      ar_rd[inst] = ar_cnt[inst];
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         c_flush[k] = 1'b0;
         c_pc[k]    = '0;
         o_next[k]  = 1'b0;
         ar_rd[k]   = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_arvalid", 32'(m_arvalid[0]), 32'd0);
      check("rst_rready", 32'(m_rready[0]), 32'd0);
      check("rst_valid", 32'(o_valid[0]), 32'd0);
      check("rst_pred", 32'(o_pred[0]), 32'd0);
      check("rst_err", 32'(o_err[0]), 32'd0);
      check("rst_araddr", m_araddr[0], 32'd0);
      check("rst_arlen", 32'(m_arlen[0]), 32'd0);
      check("rst_arsize", 32'(m_arsize[0]), 32'd2);
      check("rst_arburst", 32'(m_arburst[0]), 32'd1);
      rst_n = 1'b1;

      // Straight-line NOPs from RESET_PC
      wait_ar(0, "boot_ar", 32'h100, 8'd3);
      pop_check(0, "boot0", 32'h100, 1'b0, 1'b0, 1'b1, NOP);
      pop_check(0, "boot1", 32'h104, 1'b0, 1'b0, 1'b0, NOP);
      pop_check(0, "boot2", 32'h108, 1'b0, 1'b0, 1'b0, NOP);
      pop_check(0, "boot3", 32'h10C, 1'b0, 1'b0, 1'b0, NOP);

      // JAL +0x40 on beat 2
      settle(0);
      do_flush(0, 32'h200);
      check("flush_clr", 32'(o_valid[0]), 32'd0);
      wait_ar(0, "jal_ar0", 32'h200, 8'd3);
      wait_ar(0, "jal_ar1", 32'h244, 8'd3);
      pop_check(0, "jal0", 32'h200, 1'b0, 1'b0, 1'b0, NOP);
      pop_check(0, "jal1", 32'h204, 1'b1, 1'b0, 1'b1, JAL_P40);
      pop_check(0, "jal2", 32'h244, 1'b0, 1'b0, 1'b0, NOP);

      // Backward branch predicted taken
      settle(0);
      do_flush(0, 32'h300);
      wait_ar(0, "btfn_ar0", 32'h300, 8'd3);
      wait_ar(0, "btfn_ar1", 32'h2F8, 8'd3);
      pop_check(0, "btfn0", 32'h300, 1'b1, 1'b0, 1'b1, BEQ_M8);
      pop_check(0, "btfn1", 32'h2F8, 1'b0, 1'b0, 1'b0, NOP);

      // Flush timing from idle, then a second flush on beat 2 of the new burst
      settle(0);
      c_flush[0] = 1'b1;
      c_pc[0]    = 32'h400;
      @(negedge clk);
      c_flush[0] = 1'b0;
      check("fl_t1_arvalid", 32'(m_arvalid[0]), 32'd1);
      check("fl_t1_araddr", m_araddr[0], 32'h400);
      check("fl_t1_valid", 32'(o_valid[0]), 32'd0);
      @(negedge clk);
      check("fl_t2_valid", 32'(o_valid[0]), 32'd0);
      @(negedge clk);
      check("fl_t3_valid", 32'(o_valid[0]), 32'd1);
      check("fl_t3_pc", o_pc[0], 32'h400);
      c_flush[0] = 1'b1;
      c_pc[0]    = 32'h802;
      @(negedge clk);
      c_flush[0] = 1'b0;
      check("fl_t4_valid", 32'(o_valid[0]), 32'd0);
      wait_ar(0, "mid_ar0", 32'h400, 8'd3);
      wait_ar(0, "mid_ar1", 32'h800, 8'd3);
      pop_check(0, "mid0", 32'h800, 1'b0, 1'b0, 1'b0, NOP);

      // 4 KB boundary split
      settle(0);
      do_flush(0, 32'hFF8);
      wait_ar(0, "4k_ar0", 32'hFF8, 8'd1);
      wait_ar(0, "4k_ar1", 32'h1000, 8'd3);
      pop_check(0, "4k0", 32'hFF8, 1'b0, 1'b0, 1'b0, NOP);
      pop_check(0, "4k1", 32'hFFC, 1'b0, 1'b0, 1'b0, NOP);
      pop_check(0, "4k2", 32'h1000, 1'b0, 1'b0, 1'b0, NOP);

      // SLVERR on beat 1 halts fetch until the next flush
      settle(0);
      do_flush(0, 32'h2000);
      wait_ar(0, "err_ar", 32'h2000, 8'd3);
      pop_check(0, "err0", 32'h2000, 1'b0, 1'b1, 1'b0, NOP);
      repeat (50) @(negedge clk);
      check("err_halt_ar", 32'(ar_cnt[0]), 32'(ar_rd[0]));
      check("err_halt_valid", 32'(o_valid[0]), 32'd0);
      do_flush(0, 32'h3000);
      wait_ar(0, "err_resume_ar", 32'h3000, 8'd3);
      pop_check(0, "err_resume0", 32'h3000, 1'b0, 1'b0, 1'b0, NOP);

      // Instance 1: branch not predicted, 4-entry queue held full
      wait_ar(1, "nb_ar0", 32'h2FC, 8'd1);
      wait_ar(1, "nb_ar1", 32'h304, 8'd1);
      check("full_no_ar", 32'(ar_cnt[1]), 32'd2);
      pop_check(1, "nb0", 32'h2FC, 1'b0, 1'b0, 1'b0, NOP);
      repeat (30) @(negedge clk);
      check("credit_no_ar", 32'(ar_cnt[1]), 32'd2);
      pop_check(1, "nb1", 32'h300, 1'b0, 1'b0, 1'b1, BEQ_M8);
      wait_ar(1, "credit_ar", 32'h30C, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
